main_mem_responder: RTL

//  Memory-side responder for the cache<->memory request interface (mem_req_* / mem_resp_*).
//  It is the responder that the direct-mapped caches talk to.
//  - Reads: one accepted request returns a 4-beat burst of MEM_DATA_BITS, which is one 512-bit line.
//  - Writes: one accepted request is followed by 4 masked data beats.

---
 rtl/main_mem_responder_pkg.sv | 23 ++
 rtl/main_mem_responder_array.sv | 27 ++
 rtl/main_mem_responder.sv | 132 +++++++++++++
 3 files changed

// File: rtl/main_mem_responder_pkg.sv
// Shared constants and state type for the main-memory responder.
package main_mem_responder_pkg;

    function automatic int ceil_log2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

    localparam int MEM_DATA_BITS = 128;
    localparam int MEM_MASK_BITS = MEM_DATA_BITS / 8;
    localparam int CPU_ADDR_BITS = 32;
    localparam int MEM_ADDR_BITS = CPU_ADDR_BITS - 2 - ceil_log2(MEM_DATA_BITS / 32);

    typedef enum logic [1:0] {
        MRSP_IDLE  = 2'd0,
        MRSP_WAIT  = 2'd1,
        MRSP_READ  = 2'd2,
        MRSP_WRITE = 2'd3
    } mrsp_state_t;

endpackage

// File: rtl/main_mem_responder_array.sv
// 1R1W storage with registered read data and per-byte write enables.
// A read and write to the same word in one cycle returns the old contents.
module mem_array_bytemask #(
    parameter int DEPTH_LOG2 = 14,
    parameter int DATA_BITS  = 128
) (
    input  logic                    clk,
    input  logic [DEPTH_LOG2-1:0]   rd_addr,
    output logic [DATA_BITS-1:0]    rd_data,
    input  logic                    wr_en,
    input  logic [DEPTH_LOG2-1:0]   wr_addr,
    input  logic [DATA_BITS-1:0]    wr_data,
    input  logic [DATA_BITS/8-1:0]  wr_mask
);

    logic [DATA_BITS-1:0] mem [2**DEPTH_LOG2];

    always_ff @(posedge clk) begin
        rd_data <= mem[rd_addr];
        for (int b = 0; b < DATA_BITS / 8; b++) begin
            if (wr_en && wr_mask[b]) begin
                mem[wr_addr][b*8 +: 8] <= wr_data[b*8 +: 8];
            end
        end
    end

endmodule

// File: rtl/main_mem_responder.sv
// Memory-side responder: 4-beat read bursts after a fixed latency, 4-beat masked write bursts.
//
// state      | meaning
// MRSP_IDLE  | ready for a request
// MRSP_WAIT  | read accepted, counting down access latency
// MRSP_READ  | streaming read beats 0..3
// MRSP_WRITE | taking write data beats 0..3
module main_mem_responder
    import main_mem_responder_pkg::*;
#(
    parameter int DEPTH_LOG2 = 14,
    parameter int LATENCY    = 4,
    parameter int ADDR_BITS  = MEM_ADDR_BITS
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     mem_req_valid,
    output logic                     mem_req_ready,
    input  logic [ADDR_BITS-1:0]     mem_req_addr,
    input  logic                     mem_req_rw,
    input  logic                     mem_req_data_valid,
    output logic                     mem_req_data_ready,
    input  logic [MEM_DATA_BITS-1:0] mem_req_data_bits,
    input  logic [MEM_MASK_BITS-1:0] mem_req_data_mask,
    output logic                     mem_resp_valid,
    output logic [MEM_DATA_BITS-1:0] mem_resp_data
);

    localparam int IDX_BITS = DEPTH_LOG2 - 2;
    localparam logic [3:0] LAT_LOAD = 4'(LATENCY - 1);

    mrsp_state_t state, next_state;
    logic [3:0] lat_cnt, next_lat_cnt;
    logic [1:0] beat, next_beat;
    logic [IDX_BITS-1:0] line_q, next_line;
    logic ready_q, resp_valid_q, data_ready_q;
    logic next_ready, next_resp_valid, next_data_ready;
    logic wr_en;
    logic [MEM_DATA_BITS-1:0] rd_data;
    logic unused_addr_bits;

    // Line bits beyond the array depth are dropped, so addresses wrap.
    assign unused_addr_bits = ^{mem_req_addr[ADDR_BITS-1:IDX_BITS+2], mem_req_addr[1:0]};

    always_comb begin
        next_state   = state;
        next_lat_cnt = lat_cnt;
        next_beat    = beat;
        next_line    = line_q;
        wr_en        = 1'b0;
        case (state)
            MRSP_IDLE: begin
                if (mem_req_valid && ready_q) begin
                    next_line = mem_req_addr[IDX_BITS+1:2];
                    next_beat = 2'd0;
                    if (mem_req_rw) begin
                        next_state = MRSP_WRITE;
                    end else begin
                        next_state   = MRSP_WAIT;
                        next_lat_cnt = LAT_LOAD;
                    end
                end
            end
            MRSP_WAIT: begin
                if (lat_cnt == 4'd0) begin
                    next_state = MRSP_READ;
                    next_beat  = 2'd0;
                end else begin
                    next_lat_cnt = lat_cnt - 4'd1;
                end
            end
            MRSP_READ: begin
                next_beat = beat + 2'd1;
                if (beat == 2'd3) next_state = MRSP_IDLE;
            end
            MRSP_WRITE: begin
                if (mem_req_data_valid) begin
                    wr_en     = 1'b1;
                    next_beat = beat + 2'd1;
                    if (beat == 2'd3) next_state = MRSP_IDLE;
                end
            end
            default: next_state = MRSP_IDLE;
        endcase

        // Outputs are registered from the next state so they line up with it.
        next_ready      = (next_state == MRSP_IDLE) ||
                          ((next_state == MRSP_READ) && (next_beat == 2'd3));
        next_resp_valid = (next_state == MRSP_READ);
        next_data_ready = (next_state == MRSP_WRITE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= MRSP_IDLE;
            lat_cnt      <= 4'd0;
            beat         <= 2'd0;
            line_q       <= '0;
            ready_q      <= 1'b0;
            resp_valid_q <= 1'b0;
            data_ready_q <= 1'b0;
        end else begin
            state        <= next_state;
            lat_cnt      <= next_lat_cnt;
            beat         <= next_beat;
            line_q       <= next_line;
            ready_q      <= next_ready;
            resp_valid_q <= next_resp_valid;
            data_ready_q <= next_data_ready;
        end
    end

    // Array read data is registered, so the address for the next beat goes out a cycle early.
    mem_array_bytemask #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .DATA_BITS  (MEM_DATA_BITS)
    ) u_array (
        .clk     (clk),
        .rd_addr ({next_line, next_beat}),
        .rd_data (rd_data),
        .wr_en   (wr_en && !reset),
        .wr_addr ({line_q, beat}),
        .wr_data (mem_req_data_bits),
        .wr_mask (mem_req_data_mask)
    );

    assign mem_req_ready      = ready_q;
    assign mem_req_data_ready = data_ready_q;
    assign mem_resp_valid     = resp_valid_q;
    assign mem_resp_data      = resp_valid_q ? rd_data : '0;

endmodule
